beat_generator: RTL and testbench

BEAT_GENERATOR -- requirements
Module: beat_generator

---
 rtl/beat_generator.sv | 88 ++++++++
 tb/tb_beat_generator.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/beat_generator.sv
// beat_generator: synthetic heartbeat from a bpm request via a repeated-subtraction divider.
// Ports: qzt_clk clock; rst sync active-high reset; tick_ms 1 kHz enable strobe;
//        bpm/bpm_load rate request; beat heartbeat level; period beat interval in ticks;
//        busy divider running; err last load rejected; beat_count beats since last accepted load.
// Option: define BEAT_RANGE_CHECK_EN to reject bpm outside 30..240 at load time.
module beat_generator #(
    parameter logic [15:0] MINUTE_TICKS = 16'd60000,
    parameter logic [15:0] PULSE_TICKS  = 16'd10
) (
    input  logic        qzt_clk,
    input  logic        rst,
    input  logic        tick_ms,
    input  logic [15:0] bpm,
    input  logic        bpm_load,
    output logic        beat,
    output logic [15:0] period,
    output logic        busy,
    output logic        err,
    output logic [15:0] beat_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [16:0] MIN_Q = {PULSE_TICKS, 1'b0};
    logic [1:0]  state;
    logic [15:0] bpm_q, rem, quo, tick_cnt;
    logic        bad_bpm;
`ifdef BEAT_RANGE_CHECK_EN
    assign bad_bpm = bpm < 16'd30 || bpm > 16'd240;
`else
    assign bad_bpm = bpm == 16'd0;
`endif
    assign busy = state == DIV;
    always_ff @(posedge qzt_clk) begin
        if (rst) begin
            state      <= IDLE;
            bpm_q      <= '0;
            rem        <= '0;
            quo        <= '0;
            tick_cnt   <= '0;
            period     <= '0;
            beat_count <= '0;
            beat       <= 1'b0;
            err        <= 1'b0;
        end else if (bpm_load) begin
            bpm_q <= bpm;
            rem   <= MINUTE_TICKS;
            quo   <= '0;
            beat  <= 1'b0;
            err   <= bad_bpm;
            state <= bad_bpm ? IDLE : DIV;
        end else begin
            case (state)
                DIV: begin
                    if (rem >= bpm_q) begin
                        rem <= rem - bpm_q;
                        quo <= quo + 16'd1;
                    end else begin
                        // quotient is final: publish it, then reject periods too short for a full pulse
                        period <= quo;
                        if ({1'b0, quo} < MIN_Q) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state      <= RUN;
                            tick_cnt   <= '0;
                            beat_count <= 16'd1;
                            beat       <= PULSE_TICKS != 16'd0;
                        end
                    end
                end
                RUN: begin
                    if (tick_ms) begin
                        if (tick_cnt == period - 16'd1) begin
                            tick_cnt   <= '0;
                            beat_count <= beat_count + 16'd1;
                            beat       <= PULSE_TICKS != 16'd0;
                        end else begin
                            tick_cnt <= tick_cnt + 16'd1;
                            beat     <= tick_cnt + 16'd1 < PULSE_TICKS;
                        end
                    end
                end
                default: beat <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_beat_generator.sv
// tb_beat_generator: randomized bench for beat_generator against an arithmetic reference model.
module tb_beat_generator;
    localparam int MT = 60000;
    localparam int PT = 10;
    logic        qzt_clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_ms = 1'b0;
    logic        bpm_load = 1'b0;
    logic [15:0] bpm = '0;
    logic        beat, busy, err;
    logic [15:0] period, beat_count;
    int tests = 0;
    int fails = 0;
    // model: mode 0 idle, 1 dividing, 2 running; s = strobes since entering run
    int          m_mode = 0, m_left = 0, m_q = 0, m_s = 0;
    logic [15:0] m_period = '0, m_bc = '0;
    logic        m_err = 1'b0;
    int          busy_len = 0, gap = 0;
    bit          gap_ok = 0;
    logic        beat_prev = 1'b0;

    beat_generator dut (
        .qzt_clk(qzt_clk), .rst(rst), .tick_ms(tick_ms), .bpm(bpm), .bpm_load(bpm_load),
        .beat(beat), .period(period), .busy(busy), .err(err), .beat_count(beat_count)
    );

    always #5 qzt_clk = ~qzt_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit rejected(input logic [15:0] b);
`ifdef BEAT_RANGE_CHECK_EN
        return b < 30 || b > 240;
`else
        return b == 0;
`endif
    endfunction

    task automatic cycle();
        @(posedge qzt_clk);
        if (rst) begin
            m_mode = 0; m_period = 0; m_bc = 0; m_err = 0; m_s = 0; gap_ok = 0;
        end else if (bpm_load) begin
            gap_ok = 0;
            busy_len = 0;
            if (rejected(bpm)) begin
                m_err = 1; m_mode = 0;
            end else begin
                m_err = 0; m_mode = 1; m_q = MT / int'(bpm); m_left = m_q + 1;
            end
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_period = 16'(m_q);
                if (m_q < 2 * PT) begin
                    m_err = 1; m_mode = 0;
                end else begin
                    m_mode = 2; m_s = 0; m_bc = 1;
                end
            end
        end else if (m_mode == 2 && tick_ms) begin
            m_s++;
            gap++;
            m_bc = 16'(1 + m_s / int'(m_period));
        end
        #1;
        check("beat", beat, m_mode == 2 && (m_s % int'(m_period)) < PT);
        check("busy", busy, m_mode == 1);
        check("err", err, m_err);
        check("period", period, m_period);
        check("beat_count", beat_count, m_bc);
        if (busy) busy_len++;
        if (beat && !beat_prev) begin
            if (gap_ok) check("gap", gap, m_period);
            gap = 0;
            gap_ok = 1;
        end
        beat_prev = beat;
        bpm_load = 1'b0;
        tick_ms = $urandom_range(0, 3) != 0;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic load(input logic [15:0] v);
        bpm = v;
        bpm_load = 1'b1;
        cycle();
    endtask

    task automatic wait_div();
        int i;
        for (i = 0; i < 70000 && busy; i++) cycle();
        check("div_timeout", i < 70000, 1);
    endtask

    initial begin
        run(3);
        rst = 1'b0;
        check("rst_period", period, 0);
        check("rst_beat_count", beat_count, 0);
        run(20);
        check("idle_no_beat", beat, 0);

        load(60);
        wait_div();
        check("busy_len_60", busy_len, 1001);
        check("period_60", period, 1000);
        check("beat_enter_60", beat, 1);
        begin
            int i;
            for (i = 0; i < 8000 && !(m_mode == 2 && m_s >= 2000 && m_s % 1000 == 500); i++) cycle();
            check("sync_500", i < 8000, 1);
        end
        bpm = 120; bpm_load = 1'b1; tick_ms = 1'b1;
        cycle();
        check("reload_beat_drop", beat, 0);
        check("reload_busy", busy, 1);
        wait_div();
        check("period_120", period, 500);
        check("beat_count_restart", beat_count, 1);
        run(1200);

        load(72);
        wait_div();
        check("period_72", period, 833);
        run(2200);

        load(0);
        check("err_0", err, 1);
        check("busy_0", busy, 0);
        run(30);
        check("beat_0", beat, 0);

        load(3000);
        run(2);
`ifdef BEAT_RANGE_CHECK_EN
        check("err_3000", err, 1);
        check("busy_3000", busy, 0);
`else
        wait_div();
        check("period_3000", period, 20);
        check("err_3000", err, 0);
        run(150);
`endif

        load(1);
        run(1000);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_div_busy", busy, 0);
        check("rst_div_period", period, 0);
        run(200);
        check("rst_div_no_beat", beat, 0);

        load(200);
        wait_div();
        run(700);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_run_beat_count", beat_count, 0);
        check("rst_run_beat", beat, 0);
        run(300);

        repeat (10) begin
            logic [15:0] v;
            v = $urandom_range(0, 3) == 0 ? 16'($urandom_range(2500, 5000)) : 16'($urandom_range(20, 300));
            load(v);
            if ($urandom_range(0, 4) == 0) begin
                run($urandom_range(1, 200));
                load(16'($urandom_range(30, 240)));
            end
            run($urandom_range(100, 2500));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
